// File: rtl/rename_rf_ckpt.sv
// Rename register file with checkpoints.
// Holds the architectural-to-physical name table, physical data, busy bits,
// free list and old-name table. A circular buffer of name-table/free-list
// snapshots allows single-cycle rollback after a branch mispredict.
module rename_rf_ckpt #(
  parameter int addr_width = 5,
  parameter int data_width = 32,
  parameter int name_width = 6,
  parameter int num_arch   = 32,
  parameter int num_phys   = 64,
  parameter int num_rd     = 2,
  parameter int num_ckpt   = 4,
  parameter int ckpt_width = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [addr_width-1:0]          ADDR_IN,
  input  logic                           ALLOC_E,
  output logic                           ALLOC_READY,
  output logic [name_width-1:0]          NAME_OUT,
  output logic [name_width:0]            FREE_CNT,
  input  logic [num_rd*addr_width-1:0]   ADDR_RD,
  output logic [num_rd*name_width-1:0]   NAME_RD,
  input  logic [num_rd*name_width-1:0]   NAME_D,
  output logic [num_rd*data_width-1:0]   D_OUT,
  output logic [num_rd-1:0]              VALID_OUT,
  input  logic [name_width-1:0]          NAME,
  input  logic [data_width-1:0]          D_IN,
  input  logic                           WE,
  input  logic [name_width-1:0]          NAME_F,
  input  logic                           FE,
  input  logic                           CKPT_E,
  output logic                           CKPT_READY,
  output logic [ckpt_width-1:0]          CKPT_ID,
  input  logic                           CKPT_REL,
  input  logic                           RB_E,
  input  logic [ckpt_width-1:0]          RB_ID
);

  localparam logic [ckpt_width-1:0] PTR_ONE   = ckpt_width'(1);
  localparam logic [ckpt_width:0]   CNT_ONE   = (ckpt_width+1)'(1);
  localparam logic [ckpt_width:0]   CKPT_FULL = (ckpt_width+1)'(num_ckpt);

  // Rename state
  logic [name_width-1:0] names_q [num_arch];
  logic [name_width-1:0] names_d [num_arch];
  logic [num_phys-1:0]   free_q, free_d;
  logic [num_phys-1:0]   busy_q, busy_d;
  logic [name_width-1:0] old_q   [num_phys];
  logic [data_width-1:0] phys_q  [num_phys];

  // Checkpoint buffer
  logic [name_width-1:0] ckpt_names_q [num_ckpt][num_arch];
  logic [num_phys-1:0]   ckpt_free_q  [num_ckpt];
  logic [ckpt_width-1:0] head_q, tail_q;
  logic [ckpt_width:0]   count_q;

  // Control decode
  logic [name_width-1:0] alloc_name;
  logic [name_width:0]   free_cnt;
  logic [name_width-1:0] fe_name;
  logic [num_phys-1:0]   fe_vec, alloc_vec, we_vec;
  logic [ckpt_width-1:0] rb_off;
  logic                  rb_fire, alloc_fire, ckpt_fire, rel_fire;

  // Lowest free name and free-name population count
  always_comb begin
    alloc_name = '0;
    free_cnt   = '0;
    for (int i = num_phys - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_name = name_width'(i);
      free_cnt = free_cnt + {{name_width{1'b0}}, free_q[i]};
    end
  end

  assign ALLOC_READY = |free_q;
  assign NAME_OUT    = alloc_name;
  assign FREE_CNT    = free_cnt;

  // Combinational read ports, no bypass from same-cycle writes
  for (genvar k = 0; k < num_rd; k++) begin : g_rd
    assign NAME_RD[k*name_width +: name_width] = names_q[ADDR_RD[k*addr_width +: addr_width]];
    assign D_OUT[k*data_width +: data_width]   = phys_q[NAME_D[k*name_width +: name_width]];
    assign VALID_OUT[k]                        = ~busy_q[NAME_D[k*name_width +: name_width]];
  end

  // A rollback is honoured only for slots in [head, tail); it pre-empts
  // allocation, checkpoint capture and release in the same cycle.
  assign rb_off     = RB_ID - head_q;
  assign rb_fire    = RB_E && ({1'b0, rb_off} < count_q);
  assign alloc_fire = ALLOC_E && ALLOC_READY && !rb_fire;
  assign ckpt_fire  = CKPT_E && CKPT_READY && !rb_fire;
  assign rel_fire   = CKPT_REL && (count_q != '0) && !rb_fire;
  assign CKPT_READY = count_q < CKPT_FULL;
  assign CKPT_ID    = tail_q;
  assign fe_name    = old_q[NAME_F];

  // One-hot vectors for the freed, allocated and written names
  always_comb begin
    fe_vec    = '0;
    alloc_vec = '0;
    we_vec    = '0;
    for (int i = 0; i < num_phys; i++) begin
      fe_vec[i]    = FE && (fe_name == name_width'(i));
      alloc_vec[i] = alloc_fire && (alloc_name == name_width'(i));
      we_vec[i]    = WE && (NAME == name_width'(i));
    end
  end

  // Next name table, free list and busy bits; allocation busy beats write clear
  always_comb begin
    for (int a = 0; a < num_arch; a++) names_d[a] = names_q[a];
    free_d = free_q;
    busy_d = busy_q & ~we_vec;
    if (rb_fire) begin
      for (int a = 0; a < num_arch; a++) names_d[a] = ckpt_names_q[RB_ID][a];
      free_d = ckpt_free_q[RB_ID] | fe_vec;
      busy_d = busy_d & ~free_d;
    end else begin
      if (alloc_fire) names_d[ADDR_IN] = alloc_name;
      free_d = (free_q & ~alloc_vec) | fe_vec;
      busy_d = busy_d | alloc_vec;
    end
  end

  // Name table, free list and busy bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int a = 0; a < num_arch; a++) names_q[a] <= name_width'(a);
      for (int i = 0; i < num_phys; i++) free_q[i] <= (i >= num_arch);
      busy_q <= '0;
    end else begin
      for (int a = 0; a < num_arch; a++) names_q[a] <= names_d[a];
      free_q <= free_d;
      busy_q <= busy_d;
    end
  end

  // Physical data and old-name tables carry no reset
  always_ff @(posedge CLK) begin
    if (WE) phys_q[NAME] <= D_IN;
    if (alloc_fire) old_q[alloc_name] <= names_q[ADDR_IN];
  end

  // Snapshot capture; freed names also land in stored snapshots. Writing
  // the free bit into idle slots is harmless since capture overwrites them.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < num_ckpt; s++) begin
      if (ckpt_fire && (tail_q == ckpt_width'(s))) begin
        for (int a = 0; a < num_arch; a++) ckpt_names_q[s][a] <= names_d[a];
        ckpt_free_q[s] <= free_d;
      end else begin
        ckpt_free_q[s] <= ckpt_free_q[s] | fe_vec;
      end
    end
  end

  // Checkpoint head/tail/count; rollback keeps the restored slot valid
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rb_fire) begin
      tail_q  <= RB_ID + PTR_ONE;
      count_q <= {1'b0, rb_off} + CNT_ONE;
    end else begin
      if (ckpt_fire) tail_q <= tail_q + PTR_ONE;
      if (rel_fire)  head_q <= head_q + PTR_ONE;
      if (ckpt_fire && !rel_fire)      count_q <= count_q + CNT_ONE;
      else if (rel_fire && !ckpt_fire) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rename_rf_ckpt.sv
// Bench for rename_rf_ckpt with a small configuration (4 arch, 8 phys).
// Expected outputs are queued as stimulus is applied and popped after the edge.
module tb_rename_rf_ckpt;

  localparam int AW = 2, DW = 32, NW = 3, NA = 4, NP = 8, NR = 2, NC = 4, CW = 2;

  logic               CLK = 1'b0;
  logic               RST;
  logic [AW-1:0]      ADDR_IN;
  logic               ALLOC_E;
  logic               ALLOC_READY;
  logic [NW-1:0]      NAME_OUT;
  logic [NW:0]        FREE_CNT;
  logic [NR*AW-1:0]   ADDR_RD;
  logic [NR*NW-1:0]   NAME_RD;
  logic [NR*NW-1:0]   NAME_D;
  logic [NR*DW-1:0]   D_OUT;
  logic [NR-1:0]      VALID_OUT;
  logic [NW-1:0]      NAME;
  logic [DW-1:0]      D_IN;
  logic               WE;
  logic [NW-1:0]      NAME_F;
  logic               FE;
  logic               CKPT_E;
  logic               CKPT_READY;
  logic [CW-1:0]      CKPT_ID;
  logic               CKPT_REL;
  logic               RB_E;
  logic [CW-1:0]      RB_ID;

  always #5 CLK = ~CLK;

  rename_rf_ckpt #(
    .addr_width(AW), .data_width(DW), .name_width(NW), .num_arch(NA),
    .num_phys(NP), .num_rd(NR), .num_ckpt(NC), .ckpt_width(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR_IN(ADDR_IN), .ALLOC_E(ALLOC_E),
    .ALLOC_READY(ALLOC_READY), .NAME_OUT(NAME_OUT), .FREE_CNT(FREE_CNT),
    .ADDR_RD(ADDR_RD), .NAME_RD(NAME_RD), .NAME_D(NAME_D), .D_OUT(D_OUT),
    .VALID_OUT(VALID_OUT), .NAME(NAME), .D_IN(D_IN), .WE(WE),
    .NAME_F(NAME_F), .FE(FE), .CKPT_E(CKPT_E), .CKPT_READY(CKPT_READY),
    .CKPT_ID(CKPT_ID), .CKPT_REL(CKPT_REL), .RB_E(RB_E), .RB_ID(RB_ID)
  );

  typedef enum {S_ARDY, S_NOUT, S_FCNT, S_CRDY, S_CID,
                S_NRD0, S_NRD1, S_D0, S_D1, S_V0, S_V1} sig_e;

  typedef struct {
    sig_e        sig;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ARDY:  return 32'(ALLOC_READY);
      S_NOUT:  return 32'(NAME_OUT);
      S_FCNT:  return 32'(FREE_CNT);
      S_CRDY:  return 32'(CKPT_READY);
      S_CID:   return 32'(CKPT_ID);
      S_NRD0:  return 32'(NAME_RD[NW-1:0]);
      S_NRD1:  return 32'(NAME_RD[2*NW-1:NW]);
      S_D0:    return D_OUT[DW-1:0];
      S_D1:    return D_OUT[2*DW-1:DW];
      S_V0:    return 32'(VALID_OUT[0]);
      S_V1:    return 32'(VALID_OUT[1]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input sig_e s, input string tag, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic idle();
    ALLOC_E = 1'b0; WE = 1'b0; FE = 1'b0;
    CKPT_E = 1'b0; CKPT_REL = 1'b0; RB_E = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    ADDR_RD = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_nd(input int n0, input int n1);
    NAME_D = {NW'(n1), NW'(n0)};
  endtask

  task automatic rst_sync();
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    idle();
    ADDR_IN = '0; NAME = '0; D_IN = '0; NAME_F = '0; RB_ID = '0;
    set_rd(0, 1);
    set_nd(0, 0);

    // Reset state
    #2;
    push(S_NRD0, "rst_map0", 0);
    push(S_NRD1, "rst_map1", 1);
    push(S_FCNT, "rst_fcnt", 4);
    push(S_NOUT, "rst_nout", 4);
    push(S_ARDY, "rst_ardy", 1);
    push(S_CRDY, "rst_crdy", 1);
    push(S_CID,  "rst_cid",  0);
    #1;
    drain();
    set_rd(2, 3);
    push(S_NRD0, "rst_map2", 2);
    push(S_NRD1, "rst_map3", 3);
    #1;
    drain();
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Exhaust the free list by renaming arch 1 four times
    set_rd(1, 0);
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd1;
    for (int i = 0; i < 4; i++) begin
      push(S_NRD0, "alloc_map1", 4 + i);
      push(S_FCNT, "alloc_fcnt", 3 - i);
      push(S_ARDY, "alloc_ardy", (i < 3) ? 1 : 0);
      cyc();
    end
    push(S_NRD0, "alloc_empty_map1", 7);
    push(S_NRD1, "alloc_empty_map0", 0);
    push(S_FCNT, "alloc_empty_fcnt", 0);
    push(S_ARDY, "alloc_empty_ardy", 0);
    cyc();
    ALLOC_E = 1'b0;

    // Committing name 5 frees its predecessor name 4
    FE = 1'b1;
    NAME_F = 3'd5;
    push(S_NOUT, "free_nout", 4);
    push(S_FCNT, "free_fcnt", 1);
    push(S_ARDY, "free_ardy", 1);
    cyc();
    FE = 1'b0;

    // Asynchronous reset in the middle of an allocation
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd0;
    #2;
    RST = 1'b1;
    push(S_FCNT, "arst_fcnt", 4);
    push(S_NOUT, "arst_nout", 4);
    push(S_ARDY, "arst_ardy", 1);
    push(S_NRD0, "arst_map1", 1);
    #1;
    drain();
    ALLOC_E = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Busy/valid tracking with data writes
    set_rd(2, 0);
    set_nd(4, 5);
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd2;
    push(S_NRD0, "wr_map2", 4);
    push(S_V0,   "wr_busy4", 0);
    push(S_FCNT, "wr_fcnt", 3);
    cyc();
    ALLOC_E = 1'b0;
    WE = 1'b1;
    NAME = 3'd4;
    D_IN = 32'hA5;
    push(S_D0, "wr_data4", 32'hA5);
    push(S_V0, "wr_valid4", 1);
    cyc();
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd2;
    NAME = 3'd5;
    D_IN = 32'h3C;
    push(S_NRD0, "wr_alloc_map2", 5);
    push(S_V1,   "wr_alloc_busy5", 0);
    push(S_D1,   "wr_alloc_data5", 32'h3C);
    push(S_V0,   "wr_keep_valid4", 1);
    cyc();
    idle();

    // Checkpoint then rollback
    rst_sync();
    set_rd(3, 0);
    set_nd(5, 6);
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd3;
    push(S_NRD0, "ck_map3_a", 4);
    cyc();
    ALLOC_E = 1'b0;
    CKPT_E = 1'b1;
    push(S_CID,  "ck_cid", 1);
    push(S_CRDY, "ck_crdy", 1);
    cyc();
    CKPT_E = 1'b0;
    ALLOC_E = 1'b1;
    push(S_NRD0, "ck_map3_b", 5);
    cyc();
    ADDR_IN = 2'd0;
    push(S_NRD1, "ck_map0_b", 6);
    push(S_FCNT, "ck_fcnt_b", 1);
    push(S_V0,   "ck_busy5", 0);
    push(S_V1,   "ck_busy6", 0);
    cyc();
    ALLOC_E = 1'b0;
    RB_E = 1'b1;
    RB_ID = 2'd0;
    push(S_NRD0, "rb_map3", 4);
    push(S_NRD1, "rb_map0", 0);
    push(S_FCNT, "rb_fcnt", 3);
    push(S_NOUT, "rb_nout", 5);
    push(S_V0,   "rb_valid5", 1);
    push(S_V1,   "rb_valid6", 1);
    push(S_CID,  "rb_cid", 1);
    cyc();
    RB_E = 1'b0;

    // A free after the snapshot must survive a later rollback to it
    FE = 1'b1;
    NAME_F = 3'd4;
    push(S_FCNT, "ckfree_fcnt", 4);
    push(S_NOUT, "ckfree_nout", 3);
    cyc();
    FE = 1'b0;
    set_rd(1, 3);
    ALLOC_E = 1'b1;
    ADDR_IN = 2'd1;
    push(S_NRD0, "ckfree_map1", 3);
    push(S_FCNT, "ckfree_fcnt2", 3);
    push(S_NOUT, "ckfree_nout2", 5);
    cyc();
    ALLOC_E = 1'b0;
    RB_E = 1'b1;
    RB_ID = 2'd0;
    push(S_NRD0, "rb2_map1", 1);
    push(S_NRD1, "rb2_map3", 4);
    push(S_FCNT, "rb2_fcnt", 4);
    push(S_NOUT, "rb2_nout", 3);
    push(S_CID,  "rb2_cid", 1);
    cyc();
    RB_E = 1'b0;

    // Fill, overflow, release and wrap the checkpoint buffer
    rst_sync();
    CKPT_E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(S_CID,  "fill_cid", (i + 1) % 4);
      push(S_CRDY, "fill_crdy", (i < 3) ? 1 : 0);
      cyc();
    end
    push(S_CID,  "full_cid", 0);
    push(S_CRDY, "full_crdy", 0);
    cyc();
    CKPT_E = 1'b0;
    CKPT_REL = 1'b1;
    push(S_CRDY, "rel_crdy", 1);
    push(S_CID,  "rel_cid", 0);
    cyc();
    CKPT_REL = 1'b0;
    CKPT_E = 1'b1;
    push(S_CID,  "wrap_cid", 1);
    push(S_CRDY, "wrap_crdy", 0);
    cyc();
    CKPT_E = 1'b0;
    RB_E = 1'b1;
    RB_ID = 2'd3;
    push(S_CID,  "rbwrap_cid", 0);
    push(S_CRDY, "rbwrap_crdy", 1);
    cyc();
    RB_ID = 2'd0;
    push(S_CID,  "rbbad_cid", 0);
    push(S_CRDY, "rbbad_crdy", 1);
    cyc();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
